led_matrix_scanner: RTL and testbench

Parametrised scan driver for shift-register LED matrices, successor to the fixed 16x16 matrix output in the pong design. Holds a ROWS x COLS one-bit framebuffer written by game logic and continuously refreshes the matrix: shifts one row of column data, selects the row, latches it, then lights it for a hold period. Outputs connect directly to the RCLK/RSDI/OEB/CSDI/CCLK/LE pads behind the tristating wrapper.

---
 rtl/led_matrix_pkg.sv | 31 +++
 rtl/led_framebuffer.sv | 48 ++++
 rtl/led_matrix_scanner.sv | 169 ++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - scan FSM states and per-state tick lengths for the LED matrix scanner
package led_matrix_pkg;

  typedef enum logic [2:0] {
    BLANK,
    SHIFT_COL,
    SHIFT_ROW,
    LATCH,
    DISPLAY
  } scan_state_t;

  localparam int BLANK_TICKS     = 1;
  localparam int SHIFT_ROW_TICKS = 2;
  localparam int LATCH_TICKS     = 1;
  localparam int DUTY_STEPS      = 16;

  function automatic int state_ticks(scan_state_t s, int cols, int hold);
    case (s)
      BLANK:     return BLANK_TICKS;
      SHIFT_COL: return 2 * cols;
      SHIFT_ROW: return SHIFT_ROW_TICKS;
      LATCH:     return LATCH_TICKS;
      default:   return hold;
    endcase
  endfunction

  function automatic int row_period_ticks(int cols, int hold);
    return BLANK_TICKS + 2 * cols + SHIFT_ROW_TICKS + LATCH_TICKS + hold;
  endfunction

endpackage

// File: rtl/led_framebuffer.sv
// rtl/led_framebuffer.sv - ROWS x COLS one-bit pixel store, single write port, combinational row read
module led_framebuffer #(
  parameter int COLS = 16,
  parameter int ROWS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(COLS)-1:0] wr_x,
  input  logic [$clog2(ROWS)-1:0] wr_y,
  input  logic                    wr_data,
  input  logic [$clog2(ROWS)-1:0] rd_y,
  output logic [COLS-1:0]         rd_row
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  logic [COLS-1:0] mem [ROWS];
  logic            x_ok;
  logic            y_ok;

  // Out-of-range coordinates can only occur when a dimension is not a power of two.
  if (COLS == (1 << XW)) begin : g_x_full
    assign x_ok = 1'b1;
  end else begin : g_x_part
    assign x_ok = (wr_x < XW'(COLS));
  end

  if (ROWS == (1 << YW)) begin : g_y_full
    assign y_ok = 1'b1;
  end else begin : g_y_part
    assign y_ok = (wr_y < YW'(ROWS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        mem[r] <= '0;
      end
    end else if (wr_en && x_ok && y_ok) begin
      mem[wr_y][wr_x] <= wr_data;
    end
  end

  assign rd_row = mem[rd_y];

endmodule

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - shift-register LED matrix refresh driver; BRIGHTNESS_EN adds a 16-level duty input
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int COLS   = 16,
  parameter int ROWS   = 16,
  parameter int CLKDIV = 1,
  parameter int HOLD   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(COLS)-1:0] wr_x,
  input  logic [$clog2(ROWS)-1:0] wr_y,
  input  logic                    wr_data,
`ifdef BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic                    frame_done,
  output logic                    RCLK,
  output logic                    RSDI,
  output logic                    CSDI,
  output logic                    CCLK,
  output logic                    LE,
  output logic                    OEB
);

  localparam int YW        = $clog2(ROWS);
  localparam int MAX_TICKS = (2 * COLS > HOLD) ? 2 * COLS : HOLD;
  localparam int CW        = $clog2(MAX_TICKS);
  localparam int DW        = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  scan_state_t     state;
  scan_state_t     state_next;
  logic            tick;
  logic            state_done;
  logic [CW-1:0]   cnt;
  logic [YW-1:0]   row;
  logic [COLS-1:0] fb_row;
  logic [COLS-1:0] shreg;
  logic            lit;
  logic            rclk_d, rsdi_d, csdi_d, cclk_d, le_d, oeb_d;

  led_framebuffer #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_fb (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_x    (wr_x),
    .wr_y    (wr_y),
    .wr_data (wr_data),
    .rd_y    (row),
    .rd_row  (fb_row)
  );

  if (CLKDIV == 1) begin : g_nodiv
    assign tick = 1'b1;
  end else begin : g_div
    logic [DW-1:0] div_cnt;
    always_ff @(posedge clk) begin
      if (reset || div_cnt == DW'(CLKDIV - 1)) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
    assign tick = (div_cnt == DW'(CLKDIV - 1));
  end

  assign state_done = tick && (cnt == CW'(state_ticks(state, COLS, HOLD) - 1));

`ifdef BRIGHTNESS_EN
  logic [3:0] duty;
  always_ff @(posedge clk) begin
    if (reset) begin
      duty <= 4'hF;
    end else if (state == LATCH && state_done) begin
      duty <= brightness;
    end
  end
  assign lit = int'(cnt) < (int'(duty) + 1) * (HOLD / DUTY_STEPS);
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    state_next = state;
    if (state_done) begin
      case (state)
        BLANK:     state_next = SHIFT_COL;
        SHIFT_COL: state_next = SHIFT_ROW;
        SHIFT_ROW: state_next = LATCH;
        LATCH:     state_next = DISPLAY;
        default:   state_next = BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK;
      cnt   <= '0;
      row   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      if (state_done) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
      // Snapshot at the end of BLANK, then shift MSB-first once per low/high pair.
      if (state == BLANK && state_done) begin
        shreg <= fb_row;
      end else if (state == SHIFT_COL && tick && cnt[0]) begin
        shreg <= {shreg[COLS-2:0], 1'b0};
      end
      if (state == DISPLAY && state_done) begin
        row <= (row == YW'(ROWS - 1)) ? '0 : row + 1'b1;
      end
    end
  end

  always_comb begin
    rclk_d = 1'b0;
    rsdi_d = 1'b0;
    csdi_d = 1'b0;
    cclk_d = 1'b0;
    le_d   = 1'b0;
    oeb_d  = 1'b1;
    case (state)
      SHIFT_COL: begin
        cclk_d = cnt[0];
        csdi_d = shreg[COLS-1];
      end
      SHIFT_ROW: begin
        rclk_d = cnt[0];
        rsdi_d = (row == '0);
      end
      LATCH:   le_d  = 1'b1;
      DISPLAY: oeb_d = ~lit;
      default: ;
    endcase
  end

  // Registered pads: every output lags the FSM by one clk, uniformly.
  always_ff @(posedge clk) begin
    if (reset) begin
      RCLK       <= 1'b0;
      RSDI       <= 1'b0;
      CSDI       <= 1'b0;
      CCLK       <= 1'b0;
      LE         <= 1'b0;
      OEB        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      RCLK       <= rclk_d;
      RSDI       <= rsdi_d;
      CSDI       <= csdi_d;
      CCLK       <= cclk_d;
      LE         <= le_d;
      OEB        <= oeb_d;
      frame_done <= (state == DISPLAY) && state_done && (row == YW'(ROWS - 1));
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb/tb_led_matrix_scanner.sv - scoreboard bench for led_matrix_scanner (default and CLKDIV=3 instances)
module tb_led_matrix_scanner;

  localparam int COLS      = 16;
  localparam int ROWS      = 16;
  localparam int HOLD      = 64;
  localparam int ROW_CYC   = 4 + 2 * COLS + HOLD;
  localparam int FRAME_CYC = ROWS * ROW_CYC;
  localparam int DIV2      = 3;

  typedef struct packed {
    logic [COLS-1:0] data;
    logic            rsdi;
  } row_t;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       wr_en   = 1'b0;
  logic [3:0] wr_x    = '0;
  logic [3:0] wr_y    = '0;
  logic       wr_data = 1'b0;
`ifdef BRIGHTNESS_EN
  logic [3:0] brightness = 4'd15;
`endif
  logic       idle_en = 1'b0;
  logic [3:0] idle_xy = '0;

  logic frame_done, RCLK, RSDI, CSDI, CCLK, LE, OEB;
  logic fd2, rclk2, rsdi2, csdi2, cclk2, le2, oeb2;

  int errors = 0;
  int checks = 0;
  row_t exp_q[$];
  row_t obs_q[$];
  logic [COLS-1:0] model [ROWS];

  led_matrix_scanner #(.COLS(COLS), .ROWS(ROWS), .CLKDIV(1), .HOLD(HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
`ifdef BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .frame_done (frame_done),
    .RCLK       (RCLK),
    .RSDI       (RSDI),
    .CSDI       (CSDI),
    .CCLK       (CCLK),
    .LE         (LE),
    .OEB        (OEB)
  );

  led_matrix_scanner #(.COLS(COLS), .ROWS(ROWS), .CLKDIV(DIV2), .HOLD(HOLD)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (idle_en),
    .wr_x       (idle_xy),
    .wr_y       (idle_xy),
    .wr_data    (idle_en),
`ifdef BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .frame_done (fd2),
    .RCLK       (rclk2),
    .RSDI       (rsdi2),
    .CSDI       (csdi2),
    .CCLK       (cclk2),
    .LE         (le2),
    .OEB        (oeb2)
  );

  always #5 clk = ~clk;

  // Row capture for the default instance: CSDI on CCLK rises, RSDI on RCLK rise, pushed on LE rise.
  logic            cclk_q = 1'b0, rclk_q = 1'b0, le_q = 1'b0;
  logic [COLS-1:0] sh_mon = '0;
  logic            rsdi_cap = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      obs_q.delete();
      sh_mon   = '0;
      rsdi_cap = 1'b0;
    end else begin
      if (CCLK && !cclk_q) sh_mon = {sh_mon[COLS-2:0], CSDI};
      if (RCLK && !rclk_q) rsdi_cap = RSDI;
      if (LE && !le_q) obs_q.push_back('{data: sh_mon, rsdi: rsdi_cap});
    end
    cclk_q = CCLK;
    rclk_q = RCLK;
    le_q   = LE;
  end

  // Level-run and row-spacing tracking for the divided instance.
  int         run_len = 0, run_bad = 0, sp_bad = 0, le2_n = 0, cyc2 = 0, last_le2 = 0;
  bit         first_run = 1'b1, le2_seen = 1'b0;
  logic [5:0] vec_q = '0;
  logic       le2_q = 1'b0;
  always @(negedge clk) begin : mon2
    logic [5:0] v;
    v = {rclk2, rsdi2, csdi2, cclk2, le2, oeb2};
    cyc2++;
    if (reset) begin
      first_run = 1'b1;
      run_len   = 0;
      le2_seen  = 1'b0;
    end else begin
      if (v !== vec_q) begin
        if (!first_run && (run_len % DIV2) != 0) run_bad++;
        first_run = 1'b0;
        run_len   = 1;
      end else begin
        run_len++;
      end
      if (le2 && !le2_q) begin
        le2_n++;
        if (le2_seen && (cyc2 - last_le2) != ROW_CYC * DIV2) sp_bad++;
        le2_seen = 1'b1;
        last_le2 = cyc2;
      end
    end
    vec_q = v;
    le2_q = le2;
  end

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 2 * FRAME_CYC);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: frame_done not seen in %0d cycles", n);
    end
  endtask

  task automatic do_write(input int x, input int y, input logic d);
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_x    = 4'(x);
    wr_y    = 4'(y);
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model[y][x] = d;
  endtask

  task automatic push_model_frame();
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) exp_q.push_back('{data: model[r], rsdi: (r == 0)});
  endtask

  task automatic test_reset();
    int n;
    for (int r = 0; r < ROWS; r++) model[r] = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({RCLK, RSDI, CSDI, CCLK, LE, OEB, frame_done} !== 7'b0000010) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000010", {RCLK, RSDI, CSDI, CCLK, LE, OEB, frame_done});
    end
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!CCLK && n < 10);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL first_cclk_rise: got cycle %0d expected 3", n);
    end
  endtask

  task automatic test_pattern();
    logic [COLS-1:0] pat;
    row_t e, o;
    pat = 16'hA5C3;
    do_write(15, 0, 1'b1);
    do_write(0, 0, 1'b1);
    for (int c = 0; c < COLS; c++) do_write(c, 1, pat[c]);
    for (int c = 0; c < COLS; c++) do_write(c, 15, 1'b1);
    do_write(8, 7, 1'b1);
    wait_frame();
    obs_q.delete();
    push_model_frame();
    wait_frame();
    for (int r = 0; r < ROWS; r++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL pattern_row%0d: no row observed, expected data=%h rsdi=%b", r, e.data, e.rsdi);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL pattern_row%0d: got data=%h rsdi=%b expected data=%h rsdi=%b", r, o.data, o.rsdi, e.data, e.rsdi);
        end
      end
    end
  endtask

  task automatic measure_frame(input int exp_low);
    int n, le_n, fd_n, low, runs, bad_runs;
    logic le_p;
    n = 0; le_n = 0; fd_n = 0; low = 0; runs = 0; bad_runs = 0; le_p = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (LE && !le_p) le_n++;
      le_p = LE;
      if (frame_done) fd_n++;
      if (!OEB) begin
        low++;
      end else if (low != 0) begin
        runs++;
        if (low != exp_low) bad_runs++;
        low = 0;
      end
    end while (!frame_done && n < 2 * FRAME_CYC);
    if (low != 0) begin
      runs++;
      if (low != exp_low) bad_runs++;
    end
    checks++;
    if (n !== FRAME_CYC) begin
      errors++;
      $display("FAIL frame_period: got %0d cycles expected %0d", n, FRAME_CYC);
    end
    checks++;
    if (le_n !== ROWS) begin
      errors++;
      $display("FAIL le_per_frame: got %0d expected %0d", le_n, ROWS);
    end
    checks++;
    if (runs !== ROWS || bad_runs !== 0) begin
      errors++;
      $display("FAIL oeb_low_runs: got %0d runs with %0d of wrong length, expected %0d runs of %0d", runs, bad_runs, ROWS, exp_low);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || fd_n !== 1) begin
      errors++;
      $display("FAIL frame_done_width: got %0d samples then %b, expected 1 sample then 0", fd_n, frame_done);
    end
  endtask

  task automatic test_frame_timing();
`ifdef BRIGHTNESS_EN
    measure_frame((int'(brightness) + 1) * HOLD / 16);
`else
    measure_frame(HOLD);
`endif
  endtask

`ifdef BRIGHTNESS_EN
  task automatic test_brightness();
    brightness = 4'd3;
    wait_frame();
    measure_frame(16);
    brightness = 4'd15;
    wait_frame();
    measure_frame(HOLD);
  endtask
`endif

  task automatic test_late_write();
    row_t e, o;
    wait_frame();
    obs_q.delete();
    push_model_frame();
    // Row 2 is snapshotted 201 edges after frame_done; this write lands 14 edges later.
    repeat (214) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_x = 4'd5; wr_y = 4'd2; wr_data = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model[2][5] = 1'b1;
    wait_frame();
    for (int pass = 0; pass < 2; pass++) begin
      for (int r = 0; r < ROWS; r++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
          errors++;
          $display("FAIL late_write_p%0d_row%0d: no row observed, expected data=%h", pass, r, e.data);
        end else begin
          o = obs_q.pop_front();
          if (o !== e) begin
            errors++;
            $display("FAIL late_write_p%0d_row%0d: got data=%h rsdi=%b expected data=%h rsdi=%b", pass, r, o.data, o.rsdi, e.data, e.rsdi);
          end
        end
      end
      if (pass == 0) begin
        obs_q.delete();
        push_model_frame();
        wait_frame();
      end
    end
  endtask

  task automatic test_mid_reset();
    int n, first_cclk;
    row_t e, o;
    wait_frame();
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({RCLK, RSDI, CSDI, CCLK, LE, OEB, frame_done} !== 7'b0000010) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected 0000010", {RCLK, RSDI, CSDI, CCLK, LE, OEB, frame_done});
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < ROWS; r++) model[r] = '0;
    obs_q.delete();
    push_model_frame();
    reset = 1'b0;
    n = 0;
    first_cclk = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (CCLK && first_cclk == 0) first_cclk = n;
    end while (!frame_done && n < 2 * FRAME_CYC);
    checks++;
    if (first_cclk !== 3) begin
      errors++;
      $display("FAIL mid_reset_first_cclk: got cycle %0d expected 3", first_cclk);
    end
    checks++;
    if (n !== FRAME_CYC) begin
      errors++;
      $display("FAIL mid_reset_first_frame: got %0d cycles expected %0d", n, FRAME_CYC);
    end
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL mid_reset_row%0d: no row observed, expected data=%h", r, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL mid_reset_row%0d: got data=%h rsdi=%b expected data=%h rsdi=%b", r, o.data, o.rsdi, e.data, e.rsdi);
        end
      end
    end
  endtask

  task automatic test_clkdiv();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd2 && n < 3 * FRAME_CYC * DIV2);
    run_bad = 0;
    sp_bad  = 0;
    le2_n   = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd2 && n < 2 * FRAME_CYC * DIV2);
    checks++;
    if (n !== FRAME_CYC * DIV2) begin
      errors++;
      $display("FAIL clkdiv_frame_period: got %0d cycles expected %0d", n, FRAME_CYC * DIV2);
    end
    checks++;
    if (run_bad !== 0) begin
      errors++;
      $display("FAIL clkdiv_level_runs: got %0d runs not a multiple of %0d, expected 0", run_bad, DIV2);
    end
    checks++;
    if (sp_bad !== 0 || le2_n !== ROWS) begin
      errors++;
      $display("FAIL clkdiv_row_period: got %0d bad spacings over %0d rows, expected 0 over %0d (period %0d)", sp_bad, le2_n, ROWS, ROW_CYC * DIV2);
    end
    @(negedge clk);
    checks++;
    if (fd2 !== 1'b0) begin
      errors++;
      $display("FAIL clkdiv_frame_done_width: got %b expected 0 one clk after pulse", fd2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pattern();
    test_frame_timing();
`ifdef BRIGHTNESS_EN
    test_brightness();
`endif
    test_late_write();
    test_mid_reset();
    test_clkdiv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
